// File: rtl/p20_pkg.sv
//==============================================================================
// p20_pkg : shared state encoding and default timing for the button repeater
// Revision: 1.0
//==============================================================================
`default_nettype none

package p20_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD_DELAY = 3'd2,
    REPEAT     = 3'd3,
    REL_DB     = 3'd4
  } chan_state_e;

  localparam int unsigned DEF_TICK_DIV           = 25000;
  localparam int unsigned DEF_DEBOUNCE_TICKS     = 10;
  localparam int unsigned DEF_REPEAT_DELAY_TICKS = 500;
  localparam int unsigned DEF_REPEAT_RATE_TICKS  = 100;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/p20_button_channel.sv
//==============================================================================
// p20_button_channel : one button -- 2-FF sync, debounce, typematic repeat
// Revision: 1.0
//==============================================================================
`default_nettype none

module p20_button_channel
  import p20_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS,
  parameter int unsigned REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
  parameter int unsigned REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic button,
  output logic inc,
  output logic held
);

  localparam int unsigned CNT_MAX = max3(DEBOUNCE_TICKS, REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DB_LIM   = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] DLY_LIM  = CNT_W'(REPEAT_DELAY_TICKS);
  localparam logic [CNT_W-1:0] RATE_LIM = CNT_W'(REPEAT_RATE_TICKS);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  logic             sync1_q, sync2_q;
  chan_state_e      state_q, state_d;
  chan_state_e      ret_q, ret_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             inc_q, inc_d;
  logic             held_q, held_d;
  logic             sync;

  assign sync    = sync2_q;
  assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      ret_q   <= IDLE;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cnt_d   = cnt_q;
    inc_d   = 1'b0;
    held_d  = held_q;
    unique case (state_q)
      IDLE: begin
        if (sync) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DB_LIM) begin
            state_d = HELD_DELAY;
            cnt_d   = '0;
            inc_d   = 1'b1;
            held_d  = 1'b1;
          end
        end
      end
      HELD_DELAY: begin
        if (!sync) begin
          state_d = REL_DB;
          ret_d   = HELD_DELAY;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DLY_LIM) begin
            state_d = REPEAT;
            cnt_d   = '0;
            inc_d   = 1'b1;
          end
        end
      end
      REPEAT: begin
        if (!sync) begin
          state_d = REL_DB;
          ret_d   = REPEAT;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= RATE_LIM) begin
            cnt_d = '0;
            inc_d = 1'b1;
          end
        end
      end
      REL_DB: begin
        // A bounce back high resumes the interrupted phase from a fresh count.
        if (sync) begin
          state_d = ret_q;
          cnt_d   = '0;
        end else if (tick) begin
          cnt_d = cnt_inc;
          if (cnt_inc >= DB_LIM) begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign inc  = inc_q;
  assign held = held_q;

endmodule

`default_nettype wire

// File: rtl/p20_button_repeat.sv
//==============================================================================
// p20_button_repeat : shared ms prescaler feeding hour/minute button channels
// Revision: 1.0
//==============================================================================
`default_nettype none

module p20_button_repeat
  import p20_pkg::*;
#(
  parameter int unsigned TICK_DIV           = DEF_TICK_DIV,
  parameter int unsigned DEBOUNCE_TICKS     = DEF_DEBOUNCE_TICKS,
  parameter int unsigned REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS,
  parameter int unsigned REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic hour_button,
  input  logic minute_button,
  output logic hour_inc,
  output logic minute_inc,
  output logic hour_held,
  output logic minute_held,
  output logic tick
);

  // TICK_DIV >= 2 keeps tick low during reset and never high two cycles running.
  localparam int unsigned PS_W = $clog2(TICK_DIV);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick_w;

  assign tick_w = (ps_q == PS_W'(TICK_DIV - 1));

  always_comb begin
    ps_d = ps_q + PS_W'(1);
    if (tick_w) ps_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ps_q <= '0;
    else       ps_q <= ps_d;
  end

  p20_button_channel #(
    .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
    .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
    .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
  ) u_hour (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick_w),
    .button (hour_button),
    .inc    (hour_inc),
    .held   (hour_held)
  );

  p20_button_channel #(
    .DEBOUNCE_TICKS     (DEBOUNCE_TICKS),
    .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
    .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
  ) u_minute (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick_w),
    .button (minute_button),
    .inc    (minute_inc),
    .held   (minute_held)
  );

  assign tick = tick_w;

endmodule

`default_nettype wire
